// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared bit-level helpers for the full adder slice.
// Keeps the cell equations in one place for reuse by wider adders.
package full_adder_pkg;

    // Sum bit of a 1-bit full adder (odd parity of the three inputs).
    function automatic logic fa_sum_bit(
        input logic a,
        input logic b,
        input logic c
    );
        return a ^ b ^ c;
    endfunction

    // Carry bit of a 1-bit full adder (majority of the three inputs).
    function automatic logic fa_carry_bit(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit combinational full adder.
// Plain gate equations so X/Z on any input reaches the outputs.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        sum  = fa_sum_bit(a, b, cin);
        cout = fa_carry_bit(a, b, cin);
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder of full_adder_cell slices.
// Optional output register (sum_q/cout_q) with async active-high reset.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    // Ripple chain: slice i consumes carry[i] and drives carry[i+1].
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_d;
        logic             cout_d;

        // Load the combinational result when enabled, otherwise hold.
        always_comb begin
            sum_d  = sum_q;
            cout_d = cout_q;
            if (en) begin
                sum_d  = sum;
                cout_d = cout;
            end
        end

        // Output register; reset clears it regardless of en or clk.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end else begin : g_noreg
        assign sum_q  = '0;
        assign cout_q = 1'b0;
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: random and directed checks of full_adder at WIDTH 1 and 8
// against an arithmetic reference model.
module tb_full_adder;

    logic       clk;
    logic       rst;
    logic       a1, b1, cin1, en1;
    logic       sum1, cout1, sum1_q, cout1_q;
    logic [7:0] a8, b8;
    logic       cin8, en8;
    logic [7:0] sum8, sum8_q;
    logic       cout8, cout8_q;

    int tests;
    int fails;

    logic [8:0] ref8;
    logic [8:0] exp8_q;
    int         r1;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .a      (a1),
        .b      (b1),
        .cin    (cin1),
        .en     (en1),
        .sum    (sum1),
        .cout   (cout1),
        .sum_q  (sum1_q),
        .cout_q (cout1_q)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .cin    (cin8),
        .en     (en8),
        .sum    (sum8),
        .cout   (cout8),
        .sum_q  (sum8_q),
        .cout_q (cout8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        exp8_q = '0;
        rst  = 1'b1;
        en1  = 1'b0;
        en8  = 1'b0;
        a1   = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8   = '0;   b8 = '0;   cin8 = 1'b0;
        #1;
        check("rst_sum1_q",  sum1_q,  0);
        check("rst_cout1_q", cout1_q, 0);
        check("rst_sum8_q",  sum8_q,  0);
        check("rst_cout8_q", cout8_q, 0);

        // WIDTH=1 exhaustive sweep against a+b+cin
        for (int v = 0; v < 8; v++) begin
            a1   = v[2];
            b1   = v[1];
            cin1 = v[0];
            #10;
            r1 = int'(a1) + int'(b1) + int'(cin1);
            check($sformatf("w1_sum_%0d", v),  sum1,  r1 % 2);
            check($sformatf("w1_cout_%0d", v), cout1, r1 / 2);
        end

        // WIDTH=8 boundaries
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
        check("w8_ripple", {cout8, sum8}, 9'h100);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        check("w8_allones", {cout8, sum8}, 9'h1FF);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #1;
        check("w8_zero", {cout8, sum8}, 9'h000);

        // Register stage on WIDTH=1
        @(negedge clk);
        rst = 1'b0;
        en1 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        @(posedge clk); #1;
        check("reg_load_sum",  sum1_q,  0);
        check("reg_load_cout", cout1_q, 1);

        @(negedge clk);
        en1 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
        #1;
        check("hold_comb_sum",  sum1, 1);
        check("hold_comb_cout", cout1, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_sum_q_%0d", k),  sum1_q,  0);
            check($sformatf("hold_cout_q_%0d", k), cout1_q, 1);
        end

        // WIDTH=8 random vectors, comb and registered paths
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            en8  = 1'($urandom);
            ref8 = 9'(int'(a8) + int'(b8) + int'(cin8));
            #1;
            check("w8_rand", {cout8, sum8}, ref8);
            @(posedge clk); #1;
            if (en8)
                exp8_q = ref8;
            check("w8_rand_q", {cout8_q, sum8_q}, exp8_q);
        end

        // Async reset between edges with en=1
        @(negedge clk);
        en1 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_q", {cout1_q, sum1_q}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sum_q",  sum1_q,  0);
        check("async_rst_cout_q", cout1_q, 0);
        check("async_rst_sum8_q", {cout8_q, sum8_q}, 0);
        check("async_rst_comb", {cout1, sum1}, 2'b11);
        @(posedge clk); #1;
        check("rst_held_q", {cout1_q, sum1_q}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
